sw_stream_feeder: RTL and testbench
===================================

SW_STREAM_FEEDER -- requirements
Module: sw_stream_feeder

Interface
REQ-001 Parameter WIDTH, default 10, score/gap word width driven into PE 0.
REQ-002 Parameter NUM_PE, default 16, number of PEs in the downstream array.
REQ-003 Parameter LEN_W, default 16, width of the query and reference length fields.
REQ-004 Reset and clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle request to begin one alignment run.
REQ-008 query_len  in  LEN_W  number of query bases for the run; sampled with start.
REQ-009 ref_len  in  LEN_W  number of reference bases for the run; sampled with start.
REQ-010 q_base / q_valid / q_ready  in / in / out  2 / 1 / 1  query base stream.
REQ-011 r_base / r_valid / r_ready  in / in / out  2 / 1 / 1  reference base stream.
REQ-012 V_out, F_out  out  WIDTH  boundary score and left-gap word into PE 0; always 0.
REQ-013 S_out, store_S_out  out  2, 1  query base and store strobe into PE 0.
REQ-014 T_out, init_out  out  2, 1  reference base and compute-active strobe into PE 0.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at end of a successful run.
REQ-017 err  out  1  one-cycle pulse on rejected start or reference underrun.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_Q, STREAM_R, DRAIN and FINISH; all array-facing outputs SHALL be registered.
REQ-019 IDLE: start with 1<=query_len<=NUM_PE and ref_len>=1 latches both lengths and clears counters; state becomes LOAD_Q on the next edge.
REQ-020 IDLE: start with query_len=0, query_len>NUM_PE or ref_len=0 pulses err on the next cycle; state stays IDLE.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 LOAD_Q: q_ready=1; each q_valid&q_ready cycle drives S_out<=q_base and store_S_out<=1 on the next cycle; cycles without a handshake drive store_S_out=0 and hold S_out.
REQ-023 After the query_len-th query handshake, state SHALL move to STREAM_R; q_ready SHALL be 0 outside LOAD_Q.
REQ-024 STREAM_R: r_ready=1; each handshake drives T_out<=r_base and init_out<=1 on the next cycle.
REQ-025 STREAM_R SHALL use no bubbles: r_valid=0 before ref_len bases are accepted is an underrun; it pulses err, drives init_out=0 and T_out=0, and enters DRAIN.
REQ-026 After the ref_len-th reference handshake, state SHALL move to DRAIN; r_ready SHALL be 0 outside STREAM_R.
REQ-027 DRAIN: init_out=0, T_out=0, store_S_out=0 for exactly NUM_PE cycles, counted by a drain counter, then FINISH.
REQ-028 FINISH: pulse done for one cycle if no underrun occurred in this run; return to IDLE on the next edge.
REQ-029 Query and reference counters SHALL be LEN_W wide and compare for equality with the latched lengths; they do not wrap within a legal run.
REQ-030 V_out and F_out SHALL be constant zero, so PE 0 sees a zero boundary score and gap.
REQ-031 Latency: handshake on cycle k produces the corresponding strobe (store_S_out or init_out) on cycle k+1.

Reset
REQ-032 On rst, state SHALL become IDLE and all outputs 0 (S_out, T_out, V_out, F_out, strobes, q_ready, r_ready, busy, done, err) on the next edge.
REQ-033 rst mid-run SHALL abort with no done or err pulse; latched lengths and counters SHALL be cleared.
REQ-034 rst SHALL take priority over start and every handshake in the same cycle.

Verification
REQ-035 query_len=3, ref_len=4, streams always valid -> store_S_out high 3 consecutive cycles with S_out=q bases, then init_out high 4 consecutive cycles with T_out=r bases, 16 idle cycles, done pulse, busy low.
REQ-036 q_valid toggled 1,0,1,0,1 with query_len=3 -> store_S_out pattern 1,0,1,0,1 one cycle later; STREAM_R entered after the third handshake.
REQ-037 r_valid dropped after 2 of ref_len=5 bases -> err pulse, init_out=0 at the next cycle, 16-cycle DRAIN, no done, back to IDLE.
REQ-038 start with query_len=17 (NUM_PE=16), then with ref_len=0 -> err pulse each time, busy stays 0, q_ready stays 0.
REQ-039 rst asserted during STREAM_R at base 2 of 4 -> all outputs 0 next cycle, no done/err; a following legal start runs normally.
REQ-040 start held high during a run -> ignored; exactly one done at run end.

Source files
------------

// File: rtl/sw_stream_feeder.sv
// sw_stream_feeder
// Feeds one Smith-Waterman alignment run into PE 0 of a systolic PE array.
// The query bases are loaded first (one per store_S_out strobe), then the
// reference bases are streamed (one per init_out strobe). After the reference
// the array is given NUM_PE cycles to drain. A run then ends with a done
// pulse, or with no done pulse if the reference stream ran dry.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               single-cycle run request, honoured only in IDLE
//   query_len, ref_len  run lengths, sampled with start
//   q_base/q_valid/q_ready   query base stream (valid/ready)
//   r_base/r_valid/r_ready   reference base stream (valid/ready)
//   V_out, F_out        boundary score / left-gap word into PE 0 (always 0)
//   S_out, store_S_out  query base and store strobe into PE 0
//   T_out, init_out     reference base and compute-active strobe into PE 0
//   busy                high whenever the FSM is not in IDLE
//   done                one-cycle pulse at the end of a clean run
//   err                 one-cycle pulse on a rejected start or an underrun
//   state_dbg           current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. ready is registered and does not depend on valid. The producer must
// hold its base stable while valid is high and ready is low. The strobe that
// belongs to a transfer on edge k shows on the outputs right after edge k.
module sw_stream_feeder #(
  parameter int WIDTH  = 10,
  parameter int NUM_PE = 16,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] query_len,
  input  logic [LEN_W-1:0] ref_len,
  input  logic [1:0]       q_base,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [1:0]       r_base,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [WIDTH-1:0] V_out,
  output logic [WIDTH-1:0] F_out,
  output logic [1:0]       S_out,
  output logic             store_S_out,
  output logic [1:0]       T_out,
  output logic             init_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_dbg
);

  localparam int DRAIN_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(NUM_PE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_Q   = 3'd1,
    STREAM_R = 3'd2,
    DRAIN    = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   q_len_r;
  logic [LEN_W-1:0]   r_len_r;
  logic [LEN_W-1:0]   q_cnt;
  logic [LEN_W-1:0]   r_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               underrun;

  logic [LEN_W-1:0] q_cnt_nxt;
  logic [LEN_W-1:0] r_cnt_nxt;
  logic             start_ok;

  assign q_cnt_nxt = q_cnt + LEN_W'(1);
  assign r_cnt_nxt = r_cnt + LEN_W'(1);
  assign start_ok  = (query_len != '0) && (query_len <= LEN_W'(NUM_PE)) &&
                     (ref_len != '0);

  // PE 0 always sees a zero boundary score and gap.
  assign V_out     = '0;
  assign F_out     = '0;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q_len_r     <= '0;
      r_len_r     <= '0;
      q_cnt       <= '0;
      r_cnt       <= '0;
      drain_cnt   <= '0;
      underrun    <= 1'b0;
      q_ready     <= 1'b0;
      r_ready     <= 1'b0;
      S_out       <= '0;
      store_S_out <= 1'b0;
      T_out       <= '0;
      init_out    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Strobes and pulses are high for a single cycle only.
      store_S_out <= 1'b0;
      init_out    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              q_len_r   <= query_len;
              r_len_r   <= ref_len;
              q_cnt     <= '0;
              r_cnt     <= '0;
              drain_cnt <= '0;
              underrun  <= 1'b0;
              q_ready   <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD_Q;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD_Q: begin
          // If no transfer happens, S_out keeps its value and the strobe stays low.
          if (q_valid && q_ready) begin
            S_out       <= q_base;
            store_S_out <= 1'b1;
            q_cnt       <= q_cnt_nxt;
            if (q_cnt_nxt == q_len_r) begin
              q_ready <= 1'b0;
              r_ready <= 1'b1;
              state   <= STREAM_R;
            end
          end
        end
        STREAM_R: begin
          if (r_valid && r_ready) begin
            T_out    <= r_base;
            init_out <= 1'b1;
            r_cnt    <= r_cnt_nxt;
            if (r_cnt_nxt == r_len_r) begin
              r_ready <= 1'b0;
              state   <= DRAIN;
            end
          end else begin
            // The array cannot take bubbles, so a missing base ends the run.
            T_out    <= '0;
            err      <= 1'b1;
            underrun <= 1'b1;
            r_ready  <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          T_out <= '0;
          if (drain_cnt == DRAIN_LAST) begin
            done  <= ~underrun;
            state <= FINISH;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          q_ready <= 1'b0;
          r_ready <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_stream_feeder.sv
// Directed testbench for sw_stream_feeder (WIDTH=10, NUM_PE=16, LEN_W=16).
// flags = {busy, q_ready, r_ready, store_S_out, init_out, done, err}.
// Outputs are sampled 1 ns after each rising edge. Inputs are changed at the same point.
module tb_sw_stream_feeder;

  localparam int WIDTH  = 10;
  localparam int NUM_PE = 16;
  localparam int LEN_W  = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] query_len;
  logic [LEN_W-1:0] ref_len;
  logic [1:0]       q_base;
  logic             q_valid;
  logic             q_ready;
  logic [1:0]       r_base;
  logic             r_valid;
  logic             r_ready;
  logic [WIDTH-1:0] V_out;
  logic [WIDTH-1:0] F_out;
  logic [1:0]       S_out;
  logic             store_S_out;
  logic [1:0]       T_out;
  logic             init_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       state_dbg;

  int n_cmp;
  int n_fail;

  logic [1:0] exp_q[$];

  wire [6:0] flags = {busy, q_ready, r_ready, store_S_out, init_out, done, err};

  sw_stream_feeder #(.WIDTH(WIDTH), .NUM_PE(NUM_PE), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .query_len(query_len), .ref_len(ref_len),
    .q_base(q_base), .q_valid(q_valid), .q_ready(q_ready),
    .r_base(r_base), .r_valid(r_valid), .r_ready(r_ready),
    .V_out(V_out), .F_out(F_out), .S_out(S_out), .store_S_out(store_S_out),
    .T_out(T_out), .init_out(init_out), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; q_valid = 1'b0; r_valid = 1'b0;
    q_base = 2'd0; r_base = 2'd0; query_len = '0; ref_len = '0;
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; query_len = 16'd2; ref_len = 16'd2;
    q_valid = 1'b1; r_valid = 1'b1;
    tick(); tick();
    n_cmp++;
    if (flags !== 7'b0000000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 7'b0000000);
    end
    n_cmp++;
    if ({S_out, T_out, V_out, F_out, state_dbg} !== '0) begin
      n_fail++; $display("FAIL reset_data: got S=%0d T=%0d V=%0d F=%0d st=%0d expected all 0",
                         S_out, T_out, V_out, F_out, state_dbg);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    n_cmp++;
    if (flags !== 7'b0000000) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", flags, 7'b0000000);
    end
  endtask

  task automatic test_basic();
    logic [1:0] qb[3];
    logic [1:0] rb[4];
    qb = '{2'd1, 2'd3, 2'd2};
    rb = '{2'd0, 2'd2, 2'd3, 2'd1};
    start = 1'b1; query_len = 16'd3; ref_len = 16'd4;
    q_valid = 1'b1; r_valid = 1'b1; q_base = qb[0]; r_base = rb[0];
    tick();
    start = 1'b0;
    n_cmp++;
    if (flags !== 7'b1100000) begin
      n_fail++; $display("FAIL basic_start: got %b expected %b", flags, 7'b1100000);
    end
    for (int i = 0; i < 3; i++) begin
      q_base = qb[i];
      tick();
      n_cmp++;
      if ({flags, S_out} !== {((i < 2) ? 7'b1101000 : 7'b1011000), qb[i]}) begin
        n_fail++; $display("FAIL basic_query%0d: got flags=%b S=%0d expected flags=%b S=%0d",
                           i, flags, S_out, ((i < 2) ? 7'b1101000 : 7'b1011000), qb[i]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      r_base = rb[j];
      tick();
      n_cmp++;
      if ({flags, T_out} !== {((j < 3) ? 7'b1010100 : 7'b1000100), rb[j]}) begin
        n_fail++; $display("FAIL basic_ref%0d: got flags=%b T=%0d expected flags=%b T=%0d",
                           j, flags, T_out, ((j < 3) ? 7'b1010100 : 7'b1000100), rb[j]);
      end
    end
    idle_inputs();
    // DRAIN has 16 cycles. The first one still shows the last reference strobe.
    for (int k = 0; k < 15; k++) begin
      tick();
      n_cmp++;
      if ({flags, T_out, state_dbg} !== {7'b1000000, 2'd0, S_DRAIN}) begin
        n_fail++; $display("FAIL basic_drain%0d: got flags=%b T=%0d st=%0d expected flags=%b T=0 st=%0d",
                           k, flags, T_out, state_dbg, 7'b1000000, S_DRAIN);
      end
    end
    tick();
    n_cmp++;
    if ({flags, state_dbg} !== {7'b1000010, S_FINISH}) begin
      n_fail++; $display("FAIL basic_done: got flags=%b st=%0d expected flags=%b st=%0d",
                         flags, state_dbg, 7'b1000010, S_FINISH);
    end
    tick();
    n_cmp++;
    if ({flags, state_dbg} !== {7'b0000000, S_IDLE}) begin
      n_fail++; $display("FAIL basic_idle: got flags=%b st=%0d expected flags=%b st=%0d",
                         flags, state_dbg, 7'b0000000, S_IDLE);
    end
  endtask

  task automatic test_q_toggle();
    logic v[5];
    int   cyc;
    bit   seen;
    v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    start = 1'b1; query_len = 16'd3; ref_len = 16'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q_valid = v[i];
      q_base  = 2'(i + 1);
      tick();
      n_cmp++;
      if (store_S_out !== v[i]) begin
        n_fail++; $display("FAIL toggle_store%0d: got %b expected %b", i, store_S_out, v[i]);
      end
      if (v[i]) begin
        n_cmp++;
        if (S_out !== 2'(i + 1)) begin
          n_fail++; $display("FAIL toggle_S%0d: got %0d expected %0d", i, S_out, 2'(i + 1));
        end
      end
      n_cmp++;
      if ({state_dbg, q_ready, r_ready} !== ((i < 4) ? {S_LOAD, 2'b10} : {S_STREAM, 2'b01})) begin
        n_fail++; $display("FAIL toggle_state%0d: got st=%0d qr=%b rr=%b expected st=%0d",
                           i, state_dbg, q_ready, r_ready, (i < 4) ? S_LOAD : S_STREAM);
      end
    end
    q_valid = 1'b0; r_valid = 1'b1; r_base = 2'd2;
    tick();
    n_cmp++;
    if ({init_out, T_out} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL toggle_ref: got init=%b T=%0d expected init=1 T=2", init_out, T_out);
    end
    idle_inputs();
    seen = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen || cyc != 16) begin
      n_fail++; $display("FAIL toggle_done_latency: got seen=%0d cycles=%0d expected seen=1 cycles=16", seen, cyc);
    end
    tick();
  endtask

  task automatic test_underrun();
    start = 1'b1; query_len = 16'd1; ref_len = 16'd5;
    tick();
    start = 1'b0; q_valid = 1'b1; q_base = 2'd3;
    tick();
    n_cmp++;
    if (flags !== 7'b1011000) begin
      n_fail++; $display("FAIL underrun_query: got %b expected %b", flags, 7'b1011000);
    end
    q_valid = 1'b0; r_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      r_base = 2'(j + 2);
      tick();
      n_cmp++;
      if ({flags, T_out} !== {7'b1010100, 2'(j + 2)}) begin
        n_fail++; $display("FAIL underrun_ref%0d: got flags=%b T=%0d expected flags=%b T=%0d",
                           j, flags, T_out, 7'b1010100, 2'(j + 2));
      end
    end
    r_valid = 1'b0;
    tick();
    n_cmp++;
    if ({flags, T_out, state_dbg} !== {7'b1000001, 2'd0, S_DRAIN}) begin
      n_fail++; $display("FAIL underrun_err: got flags=%b T=%0d st=%0d expected flags=%b T=0 st=%0d",
                         flags, T_out, state_dbg, 7'b1000001, S_DRAIN);
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      n_cmp++;
      if ({flags, state_dbg} !== {7'b1000000, S_DRAIN}) begin
        n_fail++; $display("FAIL underrun_drain%0d: got flags=%b st=%0d expected flags=%b st=%0d",
                           k, flags, state_dbg, 7'b1000000, S_DRAIN);
      end
    end
    tick();
    n_cmp++;
    if ({flags, state_dbg} !== {7'b1000000, S_FINISH}) begin
      n_fail++; $display("FAIL underrun_finish_no_done: got flags=%b st=%0d expected flags=%b st=%0d",
                         flags, state_dbg, 7'b1000000, S_FINISH);
    end
    tick();
    n_cmp++;
    if ({flags, state_dbg} !== {7'b0000000, S_IDLE}) begin
      n_fail++; $display("FAIL underrun_idle: got flags=%b st=%0d expected flags=0 st=0", flags, state_dbg);
    end
  endtask

  task automatic test_reject();
    logic [LEN_W-1:0] ql[3];
    logic [LEN_W-1:0] rl[3];
    ql = '{16'd17, 16'd3, 16'd0};
    rl = '{16'd4, 16'd0, 16'd2};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; query_len = ql[i]; ref_len = rl[i];
      tick();
      start = 1'b0;
      n_cmp++;
      if ({flags, state_dbg} !== {7'b0000001, S_IDLE}) begin
        n_fail++; $display("FAIL reject%0d_err: got flags=%b st=%0d expected flags=%b st=0",
                           i, flags, state_dbg, 7'b0000001);
      end
      tick();
      n_cmp++;
      if (flags !== 7'b0000000) begin
        n_fail++; $display("FAIL reject%0d_clear: got %b expected %b", i, flags, 7'b0000000);
      end
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid();
    int cyc;
    bit seen;
    start = 1'b1; query_len = 16'd2; ref_len = 16'd4;
    tick();
    start = 1'b0; q_valid = 1'b1;
    tick(); tick();
    q_valid = 1'b0; r_valid = 1'b1; r_base = 2'd1;
    tick(); tick();
    n_cmp++;
    if ({flags, state_dbg} !== {7'b1010100, S_STREAM}) begin
      n_fail++; $display("FAIL rstmid_pre: got flags=%b st=%0d expected flags=%b st=%0d",
                         flags, state_dbg, 7'b1010100, S_STREAM);
    end
    // Reset wins over a legal start and a live handshake in the same cycle.
    rst = 1'b1; start = 1'b1; query_len = 16'd1; ref_len = 16'd1;
    tick();
    n_cmp++;
    if ({flags, S_out, T_out, state_dbg} !== {7'b0000000, 2'd0, 2'd0, S_IDLE}) begin
      n_fail++; $display("FAIL rstmid_clear: got flags=%b S=%0d T=%0d st=%0d expected all 0",
                         flags, S_out, T_out, state_dbg);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    n_cmp++;
    if (flags !== 7'b0000000) begin
      n_fail++; $display("FAIL rstmid_quiet: got %b expected %b", flags, 7'b0000000);
    end
    start = 1'b1; query_len = 16'd1; ref_len = 16'd1;
    tick();
    start = 1'b0; q_valid = 1'b1; q_base = 2'd2;
    tick();
    n_cmp++;
    if ({flags, S_out} !== {7'b1011000, 2'd2}) begin
      n_fail++; $display("FAIL rstmid_rerun_q: got flags=%b S=%0d expected flags=%b S=2", flags, S_out, 7'b1011000);
    end
    q_valid = 1'b0; r_valid = 1'b1; r_base = 2'd3;
    tick();
    n_cmp++;
    if ({flags, T_out} !== {7'b1000100, 2'd3}) begin
      n_fail++; $display("FAIL rstmid_rerun_r: got flags=%b T=%0d expected flags=%b T=3", flags, T_out, 7'b1000100);
    end
    idle_inputs();
    seen = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen || cyc != 16) begin
      n_fail++; $display("FAIL rstmid_rerun_done: got seen=%0d cycles=%0d expected seen=1 cycles=16", seen, cyc);
    end
    tick();
  endtask

  task automatic test_start_held();
    int n_done;
    int n_err;
    int first_done;
    n_done = 0; n_err = 0; first_done = 0;
    start = 1'b1; query_len = 16'd2; ref_len = 16'd2;
    q_valid = 1'b1; r_valid = 1'b1; q_base = 2'd1; r_base = 2'd2;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (err) n_err++;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
        start = 1'b0;
      end
    end
    n_cmp++;
    if (n_done != 1 || first_done != 21 || n_err != 0) begin
      n_fail++; $display("FAIL held_start: got done=%0d at %0d err=%0d expected done=1 at 21 err=0",
                         n_done, first_done, n_err);
    end
    n_cmp++;
    if ({busy, state_dbg} !== {1'b0, S_IDLE}) begin
      n_fail++; $display("FAIL held_idle: got busy=%b st=%0d expected busy=0 st=0", busy, state_dbg);
    end
    idle_inputs();
  endtask

  task automatic test_boundary();
    int cyc;
    bit seen;
    exp_q.delete();
    start = 1'b1; query_len = 16'd16; ref_len = 16'd1;
    tick();
    start = 1'b0; q_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      q_base = 2'((i * 3) + (i >> 2));
      exp_q.push_back(q_base);
      tick();
      n_cmp++;
      if (store_S_out !== 1'b1 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL bound_store%0d: got %b expected 1", i, store_S_out);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (S_out !== e) begin
          n_fail++; $display("FAIL bound_S%0d: got %0d expected %0d", i, S_out, e);
        end
      end
    end
    n_cmp++;
    if ({state_dbg, q_ready, r_ready, exp_q.size() == 0} !== {S_STREAM, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL bound_stream: got st=%0d qr=%b rr=%b left=%0d expected st=2 qr=0 rr=1 left=0",
                         state_dbg, q_ready, r_ready, exp_q.size());
    end
    q_valid = 1'b0; r_valid = 1'b1; r_base = 2'd1;
    tick();
    idle_inputs();
    seen = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen || cyc != 16) begin
      n_fail++; $display("FAIL bound_done: got seen=%0d cycles=%0d expected seen=1 cycles=16", seen, cyc);
    end
    tick();
  endtask

  // Sequence and report
  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_q_toggle();
    test_underrun();
    test_reject();
    test_rst_mid();
    test_start_held();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
